// File: rtl/spi_slave_core_param.sv
// Parametrised SPI slave: oversamples SCK/CS/MOSI in the clk domain, deserialises MOSI into
// WIDTH-bit words and serialises user words onto MISO with a valid/ack/underrun handshake.
module spi_slave_core_param #(
   parameter int unsigned      WIDTH       = 8,
   parameter bit               CPOL        = 1'b0,
   parameter bit               CPHA        = 1'b0,
   parameter bit               LSB_FIRST   = 1'b0,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] FILL        = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             spi_mosi,
   output logic             spi_miso,
   input  logic             spi_cs_n,
   input  logic             spi_clk,
   output logic [WIDTH-1:0] user_out,
   output logic             user_out_stb,
   input  logic [WIDTH-1:0] user_in,
   input  logic             user_in_valid,
   output logic             user_in_ack,
   output logic             tx_underrun,
   output logic             csn_state,
   output logic             csn_rise,
   output logic             csn_fall
);

   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sck_prev_q, cs_prev_q;
   logic                   sck_s, mosi_s;

   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [WIDTH-1:0] tx_reg_q, tx_reg_d;
   logic [WIDTH-1:0] user_out_q, user_out_d;
   logic             stb_q, stb_d;
   logic             miso_q, miso_d;

   logic             sck_edge, active, lead, trail, sample, shift, last_bit, load;
   logic [WIDTH-1:0] rx_next, tx_word;
   logic [CW-1:0]    tx_idx;
   logic             first_bit;

   // Sync chains reset to the idle bus state so reset release creates no edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_q  <= {SYNC_STAGES{CPOL}};
         cs_sync_q   <= {SYNC_STAGES{1'b1}};
         mosi_sync_q <= '0;
         sck_prev_q  <= CPOL;
         cs_prev_q   <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sck_s     = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign csn_state = cs_sync_q[SYNC_STAGES-1];
   assign csn_fall  = cs_prev_q & ~csn_state;
   assign csn_rise  = ~cs_prev_q & csn_state;

   // A CS fall wins over an SCK edge landing in the same cycle.
   assign sck_edge = sck_s ^ sck_prev_q;
   assign active   = ~csn_state & ~csn_fall;
   assign lead     = active & sck_edge & (sck_s != CPOL);
   assign trail    = active & sck_edge & (sck_s == CPOL);
   assign sample   = CPHA ? trail : lead;
   assign shift    = CPHA ? lead : trail;
   assign last_bit = sample & (bit_cnt_q == LAST);
   assign load     = csn_fall | last_bit;

   assign user_in_ack = load & user_in_valid;
   assign tx_underrun = load & ~user_in_valid;
   assign tx_word     = user_in_valid ? user_in : FILL;
   assign first_bit   = LSB_FIRST ? tx_word[0] : tx_word[WIDTH-1];
   assign tx_idx      = LSB_FIRST ? bit_cnt_q : LAST - bit_cnt_q;

   assign rx_next = LSB_FIRST ? {mosi_s, rx_sr_q[WIDTH-1:1]} : {rx_sr_q[WIDTH-2:0], mosi_s};

   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      rx_sr_d    = rx_sr_q;
      tx_reg_d   = tx_reg_q;
      user_out_d = user_out_q;
      stb_d      = 1'b0;
      miso_d     = miso_q;

      // Any CS transition discards a partial word.
      if (csn_rise || csn_fall) begin
         bit_cnt_d = '0;
      end

      if (sample) begin
         rx_sr_d = rx_next;
         if (bit_cnt_q == LAST) begin
            bit_cnt_d  = '0;
            user_out_d = rx_next;
            stb_d      = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end

      if (load) begin
         tx_reg_d = tx_word;
      end

      if (csn_fall && !CPHA) begin
         miso_d = first_bit;
      end else if (shift) begin
         miso_d = tx_reg_q[tx_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         rx_sr_q    <= '0;
         tx_reg_q   <= '0;
         user_out_q <= '0;
         stb_q      <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         rx_sr_q    <= rx_sr_d;
         tx_reg_q   <= tx_reg_d;
         user_out_q <= user_out_d;
         stb_q      <= stb_d;
         miso_q     <= miso_d;
      end
   end

   assign user_out     = user_out_q;
   assign user_out_stb = stb_q;
   assign spi_miso     = miso_q;

endmodule

// File: tb/tb_spi_slave_core_param.sv
// Bench for spi_slave_core_param: three instances (mode 0 W8, mode 3 W8, mode 1 W16 LSB-first)
// driven by a bit-banged master; received words go through a strobe-driven scoreboard.
module tb_spi_slave_core_param;

   localparam int H = 8;  // clk cycles per SCK half period

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  sck  = 3'b010;
   logic [2:0]  csn  = 3'b111;
   logic [2:0]  mosi = 3'b000;
   wire  [2:0]  miso;
   logic [31:0] uin0 = '0, uin1 = '0, uin2 = '0;
   logic [2:0]  uvld = 3'b000;
   wire  [7:0]  uo0, uo1;
   wire  [15:0] uo2;
   wire  [2:0]  stb, ack, und, cst, crise, cfall;

   int checks = 0;
   int failures = 0;

   logic [31:0] q0[$], q1[$], q2[$];
   int n_ack[3], n_und[3], n_rise[3], n_fall[3];
   int m_ack[3], m_und[3], m_rise[3], m_fall[3];
   logic [2:0] stb_prev = 3'b000;

   logic [31:0] f_mosi[4];
   logic [31:0] f_tx[5];
   bit          f_vld[5];

   always #5 clk = ~clk;

   spi_slave_core_param #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) dut_a (
      .clk(clk), .rst(rst), .spi_mosi(mosi[0]), .spi_miso(miso[0]), .spi_cs_n(csn[0]),
      .spi_clk(sck[0]), .user_out(uo0), .user_out_stb(stb[0]), .user_in(uin0[7:0]),
      .user_in_valid(uvld[0]), .user_in_ack(ack[0]), .tx_underrun(und[0]),
      .csn_state(cst[0]), .csn_rise(crise[0]), .csn_fall(cfall[0]));

   spi_slave_core_param #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .spi_mosi(mosi[1]), .spi_miso(miso[1]), .spi_cs_n(csn[1]),
      .spi_clk(sck[1]), .user_out(uo1), .user_out_stb(stb[1]), .user_in(uin1[7:0]),
      .user_in_valid(uvld[1]), .user_in_ack(ack[1]), .tx_underrun(und[1]),
      .csn_state(cst[1]), .csn_rise(crise[1]), .csn_fall(cfall[1]));

   spi_slave_core_param #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1)) dut_c (
      .clk(clk), .rst(rst), .spi_mosi(mosi[2]), .spi_miso(miso[2]), .spi_cs_n(csn[2]),
      .spi_clk(sck[2]), .user_out(uo2), .user_out_stb(stb[2]), .user_in(uin2[15:0]),
      .user_in_valid(uvld[2]), .user_in_ack(ack[2]), .tx_underrun(und[2]),
      .csn_state(cst[2]), .csn_rise(crise[2]), .csn_fall(cfall[2]));

   function automatic int wid(input int i);
      return (i == 2) ? 16 : 8;
   endfunction
   function automatic bit pol(input int i);
      return i == 1;
   endfunction
   function automatic bit pha(input int i);
      return i != 0;
   endfunction
   function automatic bit lsb(input int i);
      return i == 2;
   endfunction
   function automatic logic [31:0] mask(input int i);
      return (32'd1 << wid(i)) - 32'd1;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_tx(input int inst, input logic [31:0] v, input bit vld);
      case (inst)
         0: uin0 = v;
         1: uin1 = v;
         default: uin2 = v;
      endcase
      uvld[inst] = vld;
   endtask

   task automatic push_rx(input int inst, input logic [31:0] v);
      case (inst)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic count_load(input int inst, input bit vld);
      if (vld) m_ack[inst]++;
      else m_und[inst]++;
   endtask

   // One CS frame of nw words; cut>0 instead raises CS after cut bits of word 0.
   task automatic run_frame(input int inst, input int nw, input int cut);
      int w = wid(inst);
      int nloop = (cut > 0) ? 1 : nw;
      int nbits = (cut > 0) ? cut : w;
      logic [31:0] got;
      logic [31:0] exp;
      set_tx(inst, f_tx[0], f_vld[0]);
      count_load(inst, f_vld[0]);
      m_fall[inst]++;
      csn[inst] = 1'b0;
      wait_clk(H);
      for (int wi = 0; wi < nloop; wi++) begin
         got = '0;
         if (cut == 0) begin
            push_rx(inst, f_mosi[wi] & mask(inst));
            count_load(inst, f_vld[wi + 1]);
         end
         for (int j = 0; j < nbits; j++) begin
            int b = lsb(inst) ? j : w - 1 - j;
            if (!pha(inst)) begin
               mosi[inst] = f_mosi[wi][b];
               wait_clk(H);
               got[b] = miso[inst];
               sck[inst] = ~pol(inst);
               wait_clk(H);
               sck[inst] = pol(inst);
            end else begin
               sck[inst] = ~pol(inst);
               mosi[inst] = f_mosi[wi][b];
               wait_clk(H);
               got[b] = miso[inst];
               sck[inst] = pol(inst);
               wait_clk(H);
            end
            if (j == 0 && cut == 0) set_tx(inst, f_tx[wi + 1], f_vld[wi + 1]);
         end
         if (cut == 0) begin
            exp = f_vld[wi] ? (f_tx[wi] & mask(inst)) : mask(inst);
            check($sformatf("miso_i%0d_w%0d", inst, wi), got, exp);
         end
      end
      wait_clk(H);
      csn[inst] = 1'b1;
      m_rise[inst]++;
      wait_clk(H);
   endtask

   task automatic pop_rx(input int inst, input logic [31:0] got);
      logic [31:0] exp;
      int sz;
      case (inst)
         0: sz = q0.size();
         1: sz = q1.size();
         default: sz = q2.size();
      endcase
      if (sz == 0) begin
         checks++;
         failures++;
         $display("FAIL rx_spurious_i%0d got=%h expected=no strobe", inst, got);
      end else begin
         case (inst)
            0: exp = q0.pop_front();
            1: exp = q1.pop_front();
            default: exp = q2.pop_front();
         endcase
         check($sformatf("rx_i%0d", inst), got, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each strobe and tallies handshake pulses.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (stb[i] && stb_prev[i]) check($sformatf("stb_width_i%0d", i), 32'd2, 32'd1);
         if (stb[i] && !stb_prev[i]) begin
            case (i)
               0: pop_rx(0, 32'(uo0));
               1: pop_rx(1, 32'(uo1));
               default: pop_rx(2, 32'(uo2));
            endcase
         end
         if (ack[i]) n_ack[i]++;
         if (und[i]) n_und[i]++;
         if (crise[i]) n_rise[i]++;
         if (cfall[i]) n_fall[i]++;
      end
      stb_prev <= stb;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         n_ack[i] = 0; n_und[i] = 0; n_rise[i] = 0; n_fall[i] = 0;
         m_ack[i] = 0; m_und[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
      end
      wait_clk(3);
      rst = 1'b0;
      check("rst_csn_state", 32'(cst), 32'h7);
      check("rst_user_out", {uo2, uo1, uo0}, 32'h0);
      check("rst_miso", 32'(miso), 32'h0);
      check("rst_pulses", {stb, ack, und, crise, cfall}, 32'h0);
      wait_clk(4);

      // Mode 0: 0xA5 in, 0xBA out; nothing valid for the follow-on load.
      f_mosi[0] = 32'hA5; f_tx[0] = 32'hBA; f_vld[0] = 1; f_tx[1] = 0; f_vld[1] = 0;
      run_frame(0, 1, 0);

      // Mode 3: three back-to-back bytes; fourth word consumed at the final sample edge.
      f_mosi[0] = 32'h01; f_mosi[1] = 32'h80; f_mosi[2] = 32'hFF;
      f_tx[0] = 32'h11; f_tx[1] = 32'h22; f_tx[2] = 32'h33; f_tx[3] = 32'h44;
      for (int k = 0; k < 4; k++) f_vld[k] = 1;
      run_frame(1, 3, 0);

      // Mode 1, 16-bit LSB-first.
      f_mosi[0] = 32'h1234; f_tx[0] = 32'hBEEF; f_vld[0] = 1; f_tx[1] = 0; f_vld[1] = 0;
      run_frame(2, 1, 0);

      // Underrun at CS fall sends FILL.
      f_mosi[0] = 32'h5A; f_tx[0] = 32'h77; f_vld[0] = 0; f_tx[1] = 32'h66; f_vld[1] = 1;
      run_frame(0, 1, 0);

      // CS raised after 5 bits, then a full 0x3C.
      f_mosi[0] = 32'hC3; f_tx[0] = 32'h99; f_vld[0] = 1;
      run_frame(0, 1, 5);
      f_mosi[0] = 32'h3C; f_tx[0] = 32'h81; f_vld[0] = 1; f_tx[1] = 0; f_vld[1] = 0;
      run_frame(0, 1, 0);

      // Synchronous reset mid-byte, CS released in the same cycle.
      set_tx(0, 32'h42, 1'b1);
      count_load(0, 1'b1);
      m_fall[0]++;
      csn[0] = 1'b0;
      wait_clk(H);
      for (int j = 0; j < 3; j++) begin
         mosi[0] = 1'b1;
         wait_clk(H);
         sck[0] = 1'b1;
         wait_clk(H);
         sck[0] = 1'b0;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      csn[0] = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_csn_state", 32'(cst), 32'h7);
      check("mid_rst_user_out", {uo2, uo1, uo0}, 32'h0);
      check("mid_rst_miso", 32'(miso), 32'h0);
      check("mid_rst_pulses", {stb, ack, und, crise, cfall}, 32'h0);
      wait_clk(H);
      f_mosi[0] = 32'h96; f_tx[0] = 32'hE7; f_vld[0] = 1; f_tx[1] = 0; f_vld[1] = 0;
      run_frame(0, 1, 0);

      // Randomised frames on every instance.
      for (int inst = 0; inst < 3; inst++) begin
         for (int r = 0; r < 6; r++) begin
            int nw = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) f_mosi[k] = $urandom & mask(inst);
            for (int k = 0; k < 5; k++) begin
               f_tx[k]  = $urandom & mask(inst);
               f_vld[k] = ($urandom_range(0, 3) != 0);
            end
            run_frame(inst, nw, 0);
         end
      end

      wait_clk(4 * H);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("ack_count_i%0d", i), n_ack[i], m_ack[i]);
         check($sformatf("underrun_count_i%0d", i), n_und[i], m_und[i]);
         check($sformatf("rise_count_i%0d", i), n_rise[i], m_rise[i]);
         check($sformatf("fall_count_i%0d", i), n_fall[i], m_fall[i]);
      end
      check("rx_pending_i0", q0.size(), 0);
      check("rx_pending_i1", q1.size(), 0);
      check("rx_pending_i2", q2.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
